// File: rtl/processor_gen2_if.sv
// processor_gen2_if: request/response bus between the processor core and its APB master.
// The core drives the read/write requests and the APB master answers with done strobes.
interface processor_gen2_if #(
  parameter int DATA_W     = 16,
  parameter int APB_ADDR_W = 9
);
  logic                  wr_en;
  logic [APB_ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  wr_done;
  logic                  rd_en;
  logic [APB_ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_done;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  wr_done, rd_data, rd_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output wr_done, rd_data, rd_done
  );
endinterface

// File: rtl/processor_gen2.sv
// processor_gen2: small multi-cycle processor with a loadable program memory,
// a register file, APB load/store through an external master, a single-level
// interrupt and a halt state. Instruction word is the low 16 bits of a memory word:
// op=[15:12], rd=[11:8], rs=[7:4], target=[11:0]; two-word ops carry imm/APB address next.
module processor_gen2 #(
  parameter int DATA_W     = 16,
  parameter int NUM_REGS   = 4,
  parameter int MEM_DEPTH  = 256,
  parameter int APB_ADDR_W = 9,
  parameter int PROG_START = 'h020,
  parameter int INT_VEC    = 'h010,
  localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_done,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  input  logic              irq,
  output logic              irq_ack,
  output logic              halted,
  output logic              illegal,
  processor_gen2_if.master  bus
);

  // Controller states
  localparam logic [3:0] S_INIT    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_OPERAND = 4'd3;
  localparam logic [3:0] S_EXEC    = 4'd4;
  localparam logic [3:0] S_RD_WAIT = 4'd5;
  localparam logic [3:0] S_WR_WAIT = 4'd6;
  localparam logic [3:0] S_IRQ     = 4'd7;
  localparam logic [3:0] S_HALTED  = 4'd8;

  // Opcodes; 0xA..0xF are undefined
  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_MOV   = 4'h2;
  localparam logic [3:0] OP_MVI   = 4'h3;
  localparam logic [3:0] OP_LOAD  = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_JEZ   = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'h8;
  localparam logic [3:0] OP_RETI  = 4'h9;

  logic [3:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] saved_pc;
  logic [15:0]       instr;
  logic [DATA_W-1:0] mem_q;
  logic              z;
  logic              in_isr;
  logic              illegal_q;

  // The register file always has 16 entries so any 4-bit field indexes it
  // directly; entries at or above NUM_REGS are never written and stay zero.
  logic [DATA_W-1:0] regs [16];
  logic [DATA_W-1:0] mem  [MEM_DEPTH];

  logic                  wr_en;
  logic [APB_ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  rd_en;
  logic [APB_ADDR_W-1:0] rd_addr;

  logic [3:0]        op;
  logic [3:0]        rd_idx;
  logic [3:0]        rs_idx;
  logic              rd_ok;
  logic              rs_ok;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              two_word;
  logic              take_irq;

  assign op     = instr[15:12];
  assign rd_idx = instr[11:8];
  assign rs_idx = instr[7:4];
  assign rd_ok  = (int'(rd_idx) < NUM_REGS);
  assign rs_ok  = (int'(rs_idx) < NUM_REGS);
  assign rd_val = rd_ok ? regs[rd_idx] : '0;
  assign rs_val = rs_ok ? regs[rs_idx] : '0;
  assign sum    = rd_val + rs_val;
  assign diff   = rd_val - rs_val;

  // In DECODE the fetched word is still on mem_q, so classify from there
  assign two_word = (mem_q[15:12] == OP_MVI) || (mem_q[15:12] == OP_LOAD) ||
                    (mem_q[15:12] == OP_STORE);

  // Interrupts are only taken between instructions or while halted, never nested
  assign take_irq = irq && !in_isr;

  assign bus.wr_en   = wr_en;
  assign bus.wr_addr = wr_addr;
  assign bus.wr_data = wr_data;
  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = rd_addr;

  assign halted  = (state == S_HALTED);
  assign irq_ack = (state == S_IRQ);
  assign illegal = illegal_q;

  // PC advance with wrap at the end of program memory
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] p);
    if (p == ADDR_W'(MEM_DEPTH - 1)) return '0;
    else return p + 1'b1;
  endfunction

  // Program memory: loader writes during INIT, registered read of the word at PC every cycle
  always_ff @(posedge clk) begin
    if (state == S_INIT && init_we) mem[init_addr] <= init_data;
    mem_q <= mem[pc];
  end

  // Controller, datapath registers and APB request registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_INIT;
      pc        <= ADDR_W'(PROG_START);
      instr_pc  <= '0;
      saved_pc  <= '0;
      instr     <= '0;
      z         <= 1'b0;
      in_isr    <= 1'b0;
      illegal_q <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (!init_done && state != S_INIT) begin
      // Loader took the memory back: abandon whatever was running, keep registers
      state     <= S_INIT;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          if (init_done) begin
            pc     <= ADDR_W'(PROG_START);
            in_isr <= 1'b0;
            state  <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (take_irq) begin
            saved_pc <= pc;
            state    <= S_IRQ;
          end else begin
            instr_pc <= pc;
            pc       <= pc_inc(pc);
            state    <= S_DECODE;
          end
        end

        S_DECODE: begin
          instr <= mem_q[15:0];
          state <= two_word ? S_OPERAND : S_EXEC;
        end

        S_OPERAND: begin
          pc    <= pc_inc(pc);
          state <= S_EXEC;
        end

        S_EXEC: begin
          state <= S_FETCH;
          case (op)
            OP_ADD: begin
              if (rd_ok) regs[rd_idx] <= sum;
              z <= (sum == '0);
            end
            OP_SUB: begin
              if (rd_ok) regs[rd_idx] <= diff;
              z <= (diff == '0);
            end
            OP_MOV: begin
              if (rd_ok) regs[rd_idx] <= rs_val;
            end
            OP_MVI: begin
              if (rd_ok) regs[rd_idx] <= mem_q;
            end
            OP_LOAD: begin
              rd_addr <= mem_q[APB_ADDR_W-1:0];
              rd_en   <= 1'b1;
              state   <= S_RD_WAIT;
            end
            OP_STORE: begin
              wr_addr <= mem_q[APB_ADDR_W-1:0];
              wr_data <= rs_val;
              wr_en   <= 1'b1;
              state   <= S_WR_WAIT;
            end
            OP_JMP: begin
              pc <= instr[ADDR_W-1:0];
            end
            OP_JEZ: begin
              if (z) pc <= instr[ADDR_W-1:0];
            end
            OP_HALT: begin
              illegal_q <= 1'b0;
              state     <= S_HALTED;
            end
            OP_RETI: begin
              if (in_isr) begin
                pc     <= saved_pc;
                in_isr <= 1'b0;
              end else begin
                illegal_q <= 1'b1;
                state     <= S_HALTED;
              end
            end
            default: begin
              illegal_q <= 1'b1;
              state     <= S_HALTED;
            end
          endcase
        end

        S_RD_WAIT: begin
          if (bus.rd_done) begin
            if (rd_ok) regs[rd_idx] <= bus.rd_data;
            rd_en <= 1'b0;
            state <= S_FETCH;
          end
        end

        S_WR_WAIT: begin
          if (bus.wr_done) begin
            wr_en <= 1'b0;
            state <= S_FETCH;
          end
        end

        S_IRQ: begin
          pc     <= ADDR_W'(INT_VEC);
          in_isr <= 1'b1;
          state  <= S_FETCH;
        end

        S_HALTED: begin
          // Return address is the HALT itself so RETI lands back in HALTED
          if (take_irq) begin
            saved_pc  <= instr_pc;
            illegal_q <= 1'b0;
            state     <= S_IRQ;
          end
        end

        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_processor_gen2.sv
// tb_processor_gen2: directed programs with hand-computed APB traffic and status.
module tb_processor_gen2;

  logic        clk;
  logic        reset;
  logic        init_done;
  logic        init_we;
  logic [7:0]  init_addr;
  logic [15:0] init_data;
  logic        irq;
  logic        irq_ack;
  logic        halted;
  logic        illegal;

  int tests_run;
  int tests_failed;

  processor_gen2_if #(.DATA_W(16), .APB_ADDR_W(9)) bus ();

  processor_gen2 dut (
    .clk       (clk),
    .reset     (reset),
    .init_done (init_done),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data),
    .irq       (irq),
    .irq_ack   (irq_ack),
    .halted    (halted),
    .illegal   (illegal),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Write one program word while the core is in INIT
  task automatic load_word(input logic [7:0] a, input logic [15:0] d);
    init_we   = 1'b1;
    init_addr = a;
    init_data = d;
    @(negedge clk);
    init_we   = 1'b0;
  endtask

  // Start execution from the program start address
  task automatic applyStimulus();
    init_done = 1'b1;
  endtask

  // Wait for a write request, check it, hold wr_done off so wr_en stays up for hold cycles
  task automatic serve_write(input string tag, input logic [8:0] a, input logic [15:0] d, input int hold);
    int n;
    int unstable;
    n = 0;
    unstable = 0;
    while (bus.wr_en !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " seen"}, 32'(bus.wr_en === 1'b1), 1);
    if (bus.wr_en !== 1'b1) return;
    checkOutput({tag, " addr"}, 32'(bus.wr_addr), 32'(a));
    checkOutput({tag, " data"}, 32'(bus.wr_data), 32'(d));
    checkOutput({tag, " rd_en"}, 32'(bus.rd_en), 0);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== a || bus.wr_data !== d) unstable++;
    end
    if (hold > 1) checkOutput({tag, " held"}, unstable, 0);
    bus.wr_done = 1'b1;
    @(negedge clk);
    bus.wr_done = 1'b0;
    checkOutput({tag, " release"}, 32'(bus.wr_en), 0);
  endtask

  // Wait for a read request, hold rd_done off for hold cycles, then return data
  task automatic serve_read(input string tag, input logic [8:0] a, input logic [15:0] d, input int hold);
    int n;
    int high;
    n = 0;
    high = 0;
    while (bus.rd_en !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " seen"}, 32'(bus.rd_en === 1'b1), 1);
    if (bus.rd_en !== 1'b1) return;
    checkOutput({tag, " addr"}, 32'(bus.rd_addr), 32'(a));
    checkOutput({tag, " wr_en"}, 32'(bus.wr_en), 0);
    high = 1;
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      if (bus.rd_en === 1'b1 && bus.rd_addr === a) high++;
    end
    checkOutput({tag, " high cycles"}, high, hold);
    bus.rd_data = d;
    bus.rd_done = 1'b1;
    @(negedge clk);
    bus.rd_done = 1'b0;
    bus.rd_data = 16'h0;
    checkOutput({tag, " release"}, 32'(bus.rd_en), 0);
  endtask

  task automatic wait_halted(input string tag);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(halted), 1);
  endtask

  initial begin
    int first_halt;
    int acks;
    int left;
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    init_done    = 1'b0;
    init_we      = 1'b0;
    init_addr    = 8'h0;
    init_data    = 16'h0;
    irq          = 1'b0;
    bus.wr_done  = 1'b0;
    bus.rd_done  = 1'b0;
    bus.rd_data  = 16'h0;

    // Reset state: every output low
    repeat (2) @(negedge clk);
    checkOutput("reset halted", 32'(halted), 0);
    checkOutput("reset illegal", 32'(illegal), 0);
    checkOutput("reset irq_ack", 32'(irq_ack), 0);
    checkOutput("reset wr_en", 32'(bus.wr_en), 0);
    checkOutput("reset rd_en", 32'(bus.rd_en), 0);
    reset = 1'b0;
    @(negedge clk);

    // Program A: MVI R0,0x13; MVI R1,0x08; ADD R0,R1; HALT -> halted on the 15th edge
    load_word(8'h20, 16'h3000);
    load_word(8'h21, 16'h0013);
    load_word(8'h22, 16'h3100);
    load_word(8'h23, 16'h0008);
    load_word(8'h24, 16'h0010);
    load_word(8'h25, 16'h8000);
    checkOutput("INIT not running", 32'(halted), 0);
    applyStimulus();
    first_halt = 0;
    for (int c = 1; c <= 40 && first_halt == 0; c++) begin
      @(negedge clk);
      if (halted === 1'b1) first_halt = c;
    end
    checkOutput("A halt cycle", first_halt, 15);
    checkOutput("A illegal", 32'(illegal), 0);

    // Abort back to INIT, registers kept for program B
    init_done = 1'b0;
    @(negedge clk);
    checkOutput("abort leaves HALTED", 32'(halted), 0);

    // Program B: stores, load, JEZ taken/not taken, MOV, SUB wrap, out-of-range reg
    load_word(8'h10, 16'h9000);
    load_word(8'h20, 16'h5000);
    load_word(8'h21, 16'h0100);
    load_word(8'h22, 16'h5010);
    load_word(8'h23, 16'h0122);
    load_word(8'h24, 16'h4000);
    load_word(8'h25, 16'h0022);
    load_word(8'h26, 16'h5000);
    load_word(8'h27, 16'h0101);
    load_word(8'h28, 16'h1000);
    load_word(8'h29, 16'h702C);
    load_word(8'h2A, 16'h5010);
    load_word(8'h2B, 16'h01FF);
    load_word(8'h2C, 16'h0110);
    load_word(8'h2D, 16'h7030);
    load_word(8'h2E, 16'h5010);
    load_word(8'h2F, 16'h0102);
    load_word(8'h30, 16'h2210);
    load_word(8'h31, 16'h3300);
    load_word(8'h32, 16'h0000);
    load_word(8'h33, 16'h1320);
    load_word(8'h34, 16'h5030);
    load_word(8'h35, 16'h0103);
    load_word(8'h36, 16'h3500);
    load_word(8'h37, 16'h0077);
    load_word(8'h38, 16'h2250);
    load_word(8'h39, 16'h5020);
    load_word(8'h3A, 16'h0104);
    load_word(8'h3B, 16'h8000);
    applyStimulus();
    serve_write("R0 after A", 9'h100, 16'h001B, 1);
    serve_write("STORE R1", 9'h122, 16'h0008, 3);
    serve_read("LOAD R0", 9'h022, 16'h00A1, 3);
    serve_write("R0 after LOAD", 9'h101, 16'h00A1, 1);
    serve_write("JEZ fallthrough", 9'h102, 16'h0010, 2);
    serve_write("SUB wrap", 9'h103, 16'hFFF0, 1);
    serve_write("R5 ignored", 9'h104, 16'h0000, 1);
    wait_halted("B halted");
    checkOutput("B illegal", 32'(illegal), 0);

    // Interrupt while halted: ISR at 0x10 is RETI, back to HALT
    acks = 0;
    left = 0;
    irq  = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (irq_ack === 1'b1) begin
        acks++;
        irq = 1'b0;
      end
      if (halted !== 1'b1) left = 1;
      else if (left == 1) break;
    end
    irq = 1'b0;
    checkOutput("irq_ack pulses", acks, 1);
    checkOutput("irq left HALTED", left, 1);
    checkOutput("RETI back to HALTED", 32'(halted), 1);
    checkOutput("irq illegal", 32'(illegal), 0);

    // Program C: reset during RD_WAIT drops rd_en at once
    init_done = 1'b0;
    @(negedge clk);
    load_word(8'h20, 16'h4000);
    load_word(8'h21, 16'h0055);
    applyStimulus();
    serve_read_wait: begin
      int n;
      n = 0;
      while (bus.rd_en !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("C rd_en up", 32'(bus.rd_en), 1);
    checkOutput("C rd_addr", 32'(bus.rd_addr), 32'h055);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async reset rd_en", 32'(bus.rd_en), 0);
    checkOutput("async reset wr_en", 32'(bus.wr_en), 0);
    checkOutput("async reset halted", 32'(halted), 0);
    init_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // After reset: registers cleared, then undefined opcode halts with illegal
    load_word(8'h20, 16'h5010);
    load_word(8'h21, 16'h0105);
    load_word(8'h22, 16'hF000);
    applyStimulus();
    serve_write("R1 cleared by reset", 9'h105, 16'h0000, 1);
    wait_halted("illegal halted");
    checkOutput("illegal flag", 32'(illegal), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
